// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_pkg
// Brief    : Shared types for the IF/MEM memory port arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } mem_access_size_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic {
        IMEM = 1'b0,
        DMEM = 1'b1
    } arb_owner_t;

    localparam int c_ctr_w = 4;

endpackage
`default_nettype wire

// File: rtl/arb_starve_ctr.sv
`default_nettype none
// ============================================================================
// Module   : arb_starve_ctr
// Brief    : Counts dmem wins over a waiting fetch and forces an imem grant.
// Revision : 1.0 - initial release
// ============================================================================
module arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_arb,
    input  logic i_imem_req,
    input  logic i_dmem_grant,
    output logic o_force
);

    localparam logic [c_ctr_w-1:0] c_limit = c_ctr_w'(STARVE_LIMIT);

    logic [c_ctr_w-1:0] r_count;

    // Any arbitration that is not a dmem win over a waiting fetch restarts the run.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (i_arb) begin
            if (i_imem_req && i_dmem_grant) begin
                r_count <= r_count + 1'b1;
            end else begin
                r_count <= '0;
            end
        end
    end

    assign o_force = i_imem_req && (r_count == c_limit);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between fetch and data access, dmem first.
//            Define ARB_ANTISTARVE_EN to enable forced fetch grants.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_ready_o,
    input  logic        imem_flush_i,
    output logic        imem_rsp_valid_o,
    output logic [31:0] imem_rsp_data_o,
    input  logic        dmem_req_i,
    input  logic [31:0] dmem_addr_i,
    input  logic        dmem_wr_enable_i,
    input  logic [1:0]  dmem_size_i,
    input  logic [31:0] dmem_wr_data_i,
    output logic        dmem_ready_o,
    output logic        dmem_rsp_valid_o,
    output logic [31:0] dmem_rsp_data_o,
    output logic        mem_valid_o,
    input  logic        mem_ready_i,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wr_data_o,
    output logic        mem_wr_enable_o,
    output logic [1:0]  mem_size_o,
    input  logic        mem_resp_i,
    input  logic [31:0] mem_rd_data_i
);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    arb_owner_t  r_owner;
    logic        r_drop;
    logic [31:0] r_rsp_data;
    logic        w_arb;
    logic        w_force;
    logic        w_grant_d;
    logic        w_grant_i;

    assign w_arb = (r_state == IDLE);

`ifdef ARB_ANTISTARVE_EN
    arb_starve_ctr #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk          (clk_i),
        .reset_n      (reset_n_i),
        .i_arb        (w_arb),
        .i_imem_req   (imem_req_i),
        .i_dmem_grant (w_grant_d),
        .o_force      (w_force)
    );
`else
    // Strict priority: the limit has no meaning without the counter.
    assign w_force = 1'b0 & (STARVE_LIMIT == 0);
`endif

    assign w_grant_d    = w_arb && dmem_req_i && !w_force;
    assign w_grant_i    = w_arb && imem_req_i && !w_grant_d;
    assign imem_ready_o = w_grant_i;
    assign dmem_ready_o = w_grant_d;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_grant_d || w_grant_i) w_state_nxt = ISSUE;
            ISSUE:   if (mem_ready_i)            w_state_nxt = WAIT;
            WAIT:    if (mem_resp_i)             w_state_nxt = RESP;
            RESP:                                w_state_nxt = IDLE;
            default:                             w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            r_owner         <= IMEM;
            r_drop          <= 1'b0;
            r_rsp_data      <= '0;
            mem_addr_o      <= '0;
            mem_wr_data_o   <= '0;
            mem_wr_enable_o <= 1'b0;
            mem_size_o      <= '0;
        end else begin
            if (w_grant_d) begin
                r_owner         <= DMEM;
                mem_addr_o      <= dmem_addr_i;
                mem_wr_data_o   <= dmem_wr_data_i;
                mem_wr_enable_o <= dmem_wr_enable_i;
                mem_size_o      <= dmem_size_i;
            end else if (w_grant_i) begin
                r_owner         <= IMEM;
                mem_addr_o      <= imem_addr_i;
                mem_wr_data_o   <= '0;
                mem_wr_enable_o <= 1'b0;
                mem_size_o      <= WORD;
            end
            if ((r_state == WAIT) && mem_resp_i) begin
                r_rsp_data <= mem_wr_enable_o ? 32'd0 : mem_rd_data_i;
            end
            // Drop flag lives only for the current fetch; RESP always returns to IDLE.
            if ((r_state == IDLE) || (r_state == RESP)) begin
                r_drop <= 1'b0;
            end else if ((r_owner == IMEM) && imem_flush_i) begin
                r_drop <= 1'b1;
            end
        end
    end

    assign mem_valid_o      = (r_state == ISSUE);
    assign imem_rsp_valid_o = (r_state == RESP) && (r_owner == IMEM) && !r_drop && !imem_flush_i;
    assign dmem_rsp_valid_o = (r_state == RESP) && (r_owner == DMEM);
    assign imem_rsp_data_o  = r_rsp_data;
    assign dmem_rsp_data_o  = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Randomized self-checking bench for mem_port_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int LIMIT = 2;
`ifdef ARB_ANTISTARVE_EN
    localparam bit ANTI = 1'b1;
`else
    localparam bit ANTI = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        imem_req_i, imem_flush_i, imem_ready_o, imem_rsp_valid_o;
    logic [31:0] imem_addr_i, imem_rsp_data_o;
    logic        dmem_req_i, dmem_wr_enable_i, dmem_ready_o, dmem_rsp_valid_o;
    logic [1:0]  dmem_size_i;
    logic [31:0] dmem_addr_i, dmem_wr_data_i, dmem_rsp_data_o;
    logic        mem_valid_o, mem_ready_i, mem_wr_enable_o, mem_resp_i;
    logic [31:0] mem_addr_o, mem_wr_data_o, mem_rd_data_i;
    logic [1:0]  mem_size_o;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i            (clk_i),
        .reset_n_i        (reset_n_i),
        .imem_req_i       (imem_req_i),
        .imem_addr_i      (imem_addr_i),
        .imem_ready_o     (imem_ready_o),
        .imem_flush_i     (imem_flush_i),
        .imem_rsp_valid_o (imem_rsp_valid_o),
        .imem_rsp_data_o  (imem_rsp_data_o),
        .dmem_req_i       (dmem_req_i),
        .dmem_addr_i      (dmem_addr_i),
        .dmem_wr_enable_i (dmem_wr_enable_i),
        .dmem_size_i      (dmem_size_i),
        .dmem_wr_data_i   (dmem_wr_data_i),
        .dmem_ready_o     (dmem_ready_o),
        .dmem_rsp_valid_o (dmem_rsp_valid_o),
        .dmem_rsp_data_o  (dmem_rsp_data_o),
        .mem_valid_o      (mem_valid_o),
        .mem_ready_i      (mem_ready_i),
        .mem_addr_o       (mem_addr_o),
        .mem_wr_data_o    (mem_wr_data_o),
        .mem_wr_enable_o  (mem_wr_enable_o),
        .mem_size_o       (mem_size_o),
        .mem_resp_i       (mem_resp_i),
        .mem_rd_data_i    (mem_rd_data_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    // Requester model: pending requests persist until granted.
    bit          i_pend, d_pend, d_we;
    logic [31:0] i_addr, d_addr, d_wdata;
    logic [1:0]  d_size;
    int          streak;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic drive_reqs();
        imem_req_i       = i_pend;
        imem_addr_i      = i_addr;
        dmem_req_i       = d_pend;
        dmem_addr_i      = d_addr;
        dmem_wr_enable_i = d_we;
        dmem_size_i      = d_size;
        dmem_wr_data_i   = d_wdata;
    endtask

    task automatic new_imem();
        i_pend = 1'b1;
        i_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic new_dmem();
        d_pend  = 1'b1;
        d_addr  = $urandom;
        d_we    = 1'($urandom_range(0, 1));
        d_size  = 2'($urandom_range(0, 2));
        d_wdata = $urandom;
    endtask

    // mode 0: random new requests, 1: both requesters busy, 2: no new requests.
    // flush_ph 0: none, 1: ISSUE, 2: WAIT, 3: RESP.
    task automatic do_txn(input int mode, input int issue_dly, input int wait_dly,
                          input int flush_ph, input logic [31:0] rd, output bit got_d);
        bit          exp_d, exp_i, t_we;
        logic [31:0] t_addr, t_wdata;
        logic [1:0]  t_size;
        got_d = 1'b0;
        if (mode == 1) begin
            if (!i_pend) new_imem();
            if (!d_pend) new_dmem();
        end else if (mode == 0) begin
            if (!i_pend && $urandom_range(0, 2) != 0) new_imem();
            if (!d_pend && $urandom_range(0, 2) != 0) new_dmem();
        end
        drive_reqs();
        #1;
        exp_d = d_pend && !(ANTI && i_pend && streak == LIMIT);
        exp_i = i_pend && !exp_d;
        check_eq("imem_ready", imem_ready_o, exp_i);
        check_eq("dmem_ready", dmem_ready_o, exp_d);
        got_d = dmem_ready_o;
        if (exp_i || !i_pend) streak = 0;
        else streak++;
        if (!exp_i && !exp_d) begin
            cycle();
            return;
        end
        t_addr  = exp_d ? d_addr  : i_addr;
        t_we    = exp_d ? d_we    : 1'b0;
        t_size  = exp_d ? d_size  : WORD;
        t_wdata = d_wdata;
        if (exp_d) d_pend = 1'b0;
        else i_pend = 1'b0;
        cycle();
        drive_reqs();
        for (int c = 0; c <= issue_dly; c++) begin
            mem_ready_i  = (c == issue_dly);
            mem_resp_i   = (c != issue_dly) ? 1'($urandom_range(0, 1)) : 1'b0;
            imem_flush_i = (flush_ph == 1) && (c == 0);
            #1;
            check_eq("mem_valid_issue", mem_valid_o, 1'b1);
            check_eq("mem_addr", mem_addr_o, t_addr);
            check_eq("mem_wr_enable", mem_wr_enable_o, t_we);
            check_eq("mem_size", mem_size_o, t_size);
            if (exp_d) check_eq("mem_wr_data", mem_wr_data_o, t_wdata);
            check_eq("ready_busy", {imem_ready_o, dmem_ready_o}, 2'b00);
            cycle();
        end
        mem_ready_i  = 1'b0;
        mem_resp_i   = 1'b0;
        imem_flush_i = 1'b0;
        for (int c = 0; c <= wait_dly; c++) begin
            mem_resp_i    = (c == wait_dly);
            mem_rd_data_i = (c == wait_dly) ? rd : $urandom;
            mem_ready_i   = 1'($urandom_range(0, 1));
            imem_flush_i  = (flush_ph == 2) && (c == 0);
            #1;
            check_eq("mem_valid_wait", mem_valid_o, 1'b0);
            check_eq("rsp_wait", {imem_rsp_valid_o, dmem_rsp_valid_o}, 2'b00);
            cycle();
        end
        mem_resp_i    = 1'b0;
        mem_ready_i   = 1'b0;
        mem_rd_data_i = $urandom;
        imem_flush_i  = (flush_ph == 3);
        #1;
        check_eq("imem_rsp_valid", imem_rsp_valid_o, !exp_d && flush_ph == 0);
        check_eq("dmem_rsp_valid", dmem_rsp_valid_o, exp_d);
        if (exp_d) check_eq("dmem_rsp_data", dmem_rsp_data_o, t_we ? 32'd0 : rd);
        else if (flush_ph == 0) check_eq("imem_rsp_data", imem_rsp_data_o, rd);
        check_eq("ready_resp", {imem_ready_o, dmem_ready_o}, 2'b00);
        cycle();
        imem_flush_i = 1'b0;
    endtask

    task automatic check_reset_outs(input string tag);
        check_eq({tag, "_valids"}, {mem_valid_o, imem_rsp_valid_o, dmem_rsp_valid_o}, 3'b000);
        check_eq({tag, "_addr"}, mem_addr_o, 32'd0);
        check_eq({tag, "_wdata"}, mem_wr_data_o, 32'd0);
        check_eq({tag, "_ctl"}, {mem_wr_enable_o, mem_size_o}, 3'b000);
        check_eq({tag, "_rdata"}, imem_rsp_data_o | dmem_rsp_data_o, 32'd0);
    endtask

    initial begin
        bit         gd;
        logic [5:0] pat;
        logic [5:0] exp_pat;
        reset_n_i = 1'b0;
        i_pend = 0; d_pend = 0; d_we = 0; i_addr = 0; d_addr = 0; d_wdata = 0; d_size = 0;
        streak = 0;
        imem_flush_i = 0; mem_ready_i = 0; mem_resp_i = 0; mem_rd_data_i = 0;
        drive_reqs();
        @(negedge clk_i);
        cycle();
        check_reset_outs("reset");
        check_eq("reset_ready", {imem_ready_o, dmem_ready_o}, 2'b00);
        reset_n_i = 1'b1;

        // Lone fetch with a one-cycle memory.
        i_pend = 1'b1;
        i_addr = 32'h100;
        do_txn(2, 0, 0, 0, 32'hDEAD_BEEF, gd);

        // Byte store with delayed memory acceptance.
        d_pend = 1'b1; d_addr = 32'h10; d_we = 1'b1; d_size = BYTE; d_wdata = 32'hAB;
        do_txn(2, 3, 0, 0, 32'h1234_5678, gd);

        // Fetch flushed while waiting for memory, then a normal fetch.
        i_pend = 1'b1; i_addr = 32'h200;
        do_txn(2, 0, 2, 2, 32'hCAFE_F00D, gd);
        i_pend = 1'b1; i_addr = 32'h204;
        do_txn(2, 0, 0, 0, 32'h0BAD_CAFE, gd);

        // Both requesters continuously busy.
        for (int k = 0; k < 6; k++) begin
            do_txn(1, 0, 0, 0, $urandom, gd);
            pat[k] = gd;
        end
        exp_pat = ANTI ? 6'b011011 : 6'b111111;
        check_eq("starve_order", pat, exp_pat);

        for (int k = 0; k < 60; k++) begin
            do_txn(0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), $urandom, gd);
        end

        // Reset while an access waits for memory; the late response must vanish.
        i_pend = 1'b0;
        d_pend = 1'b1; d_addr = 32'h400; d_we = 1'b0; d_size = WORD;
        drive_reqs();
        #1;
        check_eq("rst_grant", dmem_ready_o, 1'b1);
        d_pend = 1'b0;
        cycle();
        drive_reqs();
        mem_ready_i = 1'b1;
        cycle();
        mem_ready_i = 1'b0;
        reset_n_i = 1'b0;
        cycle();
        reset_n_i = 1'b1;
        #1;
        check_reset_outs("midreset");
        mem_resp_i = 1'b1;
        mem_rd_data_i = 32'h5555_AAAA;
        cycle();
        mem_resp_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            check_eq("late_resp", {mem_valid_o, imem_rsp_valid_o, dmem_rsp_valid_o}, 3'b000);
            cycle();
        end
        streak = 0;
        i_pend = 1'b1; i_addr = 32'h300;
        do_txn(2, 1, 1, 0, 32'h7777_1111, gd);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single external memory port between the IF-stage instruction fetch and the MEM-stage data access. Requests use a valid/ready handshake; at most one access is in flight; responses are routed back to the owner. The data side has priority, with optional anti-starvation for fetch. Sits between the pipeline stages and the memory, and feeds the stall inputs of pipeline control.

## Interface
- STARVE_LIMIT, 4: consecutive dmem grants, with imem waiting, before imem is forced a grant. Range 1..15.
- clk_i  in  1  clock
- reset_n_i  in  1  reset, synchronous, active-low
- imem_req_i  in  1  fetch request; held stable until imem_ready_o
- imem_addr_i  in  32  fetch address (always word read)
- imem_ready_o  out  1  fetch request accepted this cycle
- imem_flush_i  in  1  discard the in-flight fetch response
- imem_rsp_valid_o  out  1  fetch data valid, one-cycle pulse
- imem_rsp_data_o  out  32  fetch data
- dmem_req_i  in  1  data request; held stable until dmem_ready_o
- dmem_addr_i  in  32  data address
- dmem_wr_enable_i  in  1  1 = store, 0 = load
- dmem_size_i  in  2  mem_access_size_t (BYTE/HALF/WORD)
- dmem_wr_data_i  in  32  store data
- dmem_ready_o  out  1  data request accepted this cycle
- dmem_rsp_valid_o  out  1  load data / store ack, one-cycle pulse
- dmem_rsp_data_o  out  32  load data; 0 for stores
- mem_valid_o  out  1  request to memory
- mem_ready_i  in  1  memory accepts the request
- mem_addr_o / mem_wr_data_o  out  32  registered request fields
- mem_wr_enable_o  out  1  registered
- mem_size_o  out  2  registered; WORD for fetches
- mem_resp_i  in  1  exactly one pulse per accepted request (load data or store ack)
- mem_rd_data_i  in  32  valid with mem_resp_i

## Operation
- FSM arb_state_t: IDLE, ISSUE, WAIT, RESP.
- IDLE: arbitrate. dmem wins if dmem_req_i, except when the forced-fetch condition applies (see Configuration). The winner gets its ready_o high combinationally in the same cycle. Its fields latch into the request registers, owner latches into arb_owner_t. Next state is ISSUE. With no request, stay in IDLE.
- ISSUE: mem_valid_o=1 with the latched fields. On mem_ready_i go to WAIT; otherwise hold all fields.
- WAIT: on mem_resp_i latch mem_rd_data_i (store: latch 0) and go to RESP.
- RESP: assert the owner's rsp_valid_o for one cycle with the latched data, then go to IDLE. No arbitration in RESP.
- Flush: imem_flush_i high in any cycle of ISSUE, WAIT or RESP while owner=IMEM sets a sticky drop flag.
  - The access still completes on the memory side.
  - imem_rsp_valid_o is suppressed.
  - The flag clears on entering IDLE.
- imem_flush_i has no effect when owner=DMEM, or in IDLE. A grant in the same cycle as a flush proceeds.
- Both ready outputs are never high together. Ready outputs are 0 outside IDLE.
- mem_resp_i outside WAIT is ignored. mem_ready_i outside ISSUE is ignored.

## Timing
- Reset (reset_n_i=0 at a clk_i edge):
  - state=IDLE.
  - All outputs are 0, including mem_size_o and the rsp data.
  - Drop flag and starvation counter are cleared.
  - An in-flight access is abandoned, with no response to either side.
- Best-case latency: request accepted at N, mem_valid_o at N+1 (mem_ready_i at N+1), mem_resp_i at N+2, rsp_valid_o at N+3, next grant at N+4.
- Throughput: at most one access per 4 cycles.
- A requester may drop its req_i only after its ready_o pulse. Changing fields before then is illegal.

## Configuration
- ARB_ANTISTARVE_EN defined:
  - A 4-bit counter increments on each dmem grant made while imem_req_i=1.
  - It clears on any imem grant, and on any arbitration with imem_req_i=0.
  - When the counter equals STARVE_LIMIT and imem_req_i=1, imem wins the next arbitration even if dmem_req_i=1.
- Undefined: strict dmem priority; the counter logic is absent.

## Structure
- definitions package: arb_state_t, arb_owner_t (IMEM/DMEM), and the existing mem_access_size_t.
- Sub-module arb_starve_ctr (counter and force flag) is instantiated only under ARB_ANTISTARVE_EN.

## Test plan
- Lone fetch: imem_req_i at 0x100 with a 1-cycle memory → imem_ready_o at N, mem_addr_o=0x100 with mem_size_o=WORD at N+1, imem_rsp_valid_o carrying 0xDEADBEEF at N+3.
- Simultaneous requests: imem 0x200 and dmem load 0x400 at N → dmem_ready_o at N, imem_ready_o at N+4. Each response goes only to its owner.
- Store: dmem store BYTE 0x10 with data 0xAB at 0x3 and mem_ready_i delayed 3 cycles → fields held stable through ISSUE, dmem_rsp_valid_o=1 with data 0.
- Flush: fetch in WAIT, imem_flush_i pulse → mem_resp_i is consumed, imem_rsp_valid_o stays 0, and the next IDLE grants normally.
- Starvation, ARB_ANTISTARVE_EN, STARVE_LIMIT=2: dmem_req_i and imem_req_i both held high → grant order D, D, I, D, D, I. With the macro undefined → only D grants.
- Reset during WAIT: reset_n_i low for one cycle, then a late mem_resp_i → no rsp_valid_o; state is IDLE and the next request is granted.
